// File: rtl/hpdmc_wrpath.sv
`default_nettype none
//==============================================================================
// Module      : hpdmc_wrpath
// Description : DDR write-path sequencer. Queues write words and drives ODDR2
//               D0/D1 pairs for DQ, DM and DQS through a
//               preamble/data/postamble burst.
// Revision    : 1.0 - initial release
//==============================================================================
module hpdmc_wrpath #(
    parameter int DQ_WIDTH     = 32,
    parameter int DEPTH        = 8,
    parameter int BURST_CYCLES = 2,
    parameter int LATENCY      = 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [2*DQ_WIDTH-1:0]     wr_data,
    input  logic [2*DQ_WIDTH/8-1:0]   wr_mask,
    input  logic                      burst_start,
    output logic                      busy,
    output logic [DQ_WIDTH-1:0]       dq_d0,
    output logic [DQ_WIDTH-1:0]       dq_d1,
    output logic [DQ_WIDTH/8-1:0]     dm_d0,
    output logic [DQ_WIDTH/8-1:0]     dm_d1,
    output logic [DQ_WIDTH/8-1:0]     dqs_d0,
    output logic [DQ_WIDTH/8-1:0]     dqs_d1,
    output logic                      dq_oe,
    output logic                      dqs_oe,
    output logic                      underrun,
    output logic                      cmd_err
);

    localparam int c_NB     = DQ_WIDTH / 8;
    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_CNT_W  = c_AW + 1;
    localparam logic [c_CNT_W-1:0] c_FULL       = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_LAT_LAST   = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [3:0]         c_BURST_LAST = 4'(BURST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_PRE  = 3'd2,
        S_DATA = 3'd3,
        S_POST = 3'd4
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_phase, w_phase_nxt;
    logic [c_AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [2*DQ_WIDTH-1:0]  r_mem_data [DEPTH];
    logic [2*c_NB-1:0]      r_mem_mask [DEPTH];
    logic                   r_underrun, r_cmd_err;

    logic                   w_push, w_pop, w_empty_hit;
    logic [2*DQ_WIDTH-1:0]  w_head_data;
    logic [2*c_NB-1:0]      w_head_mask;

    logic [DQ_WIDTH-1:0]    r_dq_d0, r_dq_d1, w_dq_d0, w_dq_d1;
    logic [c_NB-1:0]        r_dm_d0, r_dm_d1, w_dm_d0, w_dm_d1;
    logic [c_NB-1:0]        r_dqs_d0, r_dqs_d1, w_dqs_d0, w_dqs_d1;
    logic                   r_dq_oe, r_dqs_oe, w_dq_oe, w_dqs_oe;

    // Next-state and phase counter; phase restarts whenever the state changes
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (burst_start) w_state_nxt = (LATENCY > 0) ? S_WAIT : S_PRE;
            S_WAIT: if (r_phase == c_LAT_LAST) w_state_nxt = S_PRE;
            S_PRE:  w_state_nxt = S_DATA;
            S_DATA: if (r_phase == c_BURST_LAST) w_state_nxt = S_POST;
            S_POST: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_phase_nxt = '0;
        if ((w_state_nxt == r_state) && ((r_state == S_WAIT) || (r_state == S_DATA)))
            w_phase_nxt = r_phase + 4'd1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state held
    assign wr_ready    = (r_count != c_FULL);
    assign w_push      = wr_valid && wr_ready;
    assign w_pop       = (w_state_nxt == S_DATA) && (r_count != '0);
    assign w_empty_hit = (w_state_nxt == S_DATA) && (r_count == '0);
    assign w_head_data = r_mem_data[r_rd_ptr];
    assign w_head_mask = r_mem_mask[r_rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (w_push && !sys_rst) begin
            r_mem_data[r_wr_ptr] <= wr_data;
            r_mem_mask[r_wr_ptr] <= wr_mask;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_dq_d0  = '0;
        w_dq_d1  = '0;
        w_dm_d0  = '1;
        w_dm_d1  = '1;
        w_dqs_d0 = '0;
        w_dqs_d1 = '0;
        w_dq_oe  = 1'b0;
        w_dqs_oe = 1'b0;
        case (w_state_nxt)
            S_PRE, S_POST: w_dqs_oe = 1'b1;
            S_DATA: begin
                w_dqs_oe = 1'b1;
                w_dq_oe  = 1'b1;
                w_dqs_d0 = '1;
                if (w_pop) begin
                    w_dq_d0 = w_head_data[2*DQ_WIDTH-1:DQ_WIDTH];
                    w_dq_d1 = w_head_data[DQ_WIDTH-1:0];
                    w_dm_d0 = w_head_mask[2*c_NB-1:c_NB];
                    w_dm_d1 = w_head_mask[c_NB-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_dq_d0    <= '0;
            r_dq_d1    <= '0;
            r_dm_d0    <= '1;
            r_dm_d1    <= '1;
            r_dqs_d0   <= '0;
            r_dqs_d1   <= '0;
            r_dq_oe    <= 1'b0;
            r_dqs_oe   <= 1'b0;
            r_underrun <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_dq_d0    <= w_dq_d0;
            r_dq_d1    <= w_dq_d1;
            r_dm_d0    <= w_dm_d0;
            r_dm_d1    <= w_dm_d1;
            r_dqs_d0   <= w_dqs_d0;
            r_dqs_d1   <= w_dqs_d1;
            r_dq_oe    <= w_dq_oe;
            r_dqs_oe   <= w_dqs_oe;
            if (w_empty_hit) r_underrun <= 1'b1;
            if (burst_start && (r_state != S_IDLE)) r_cmd_err <= 1'b1;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign dq_d0    = r_dq_d0;
    assign dq_d1    = r_dq_d1;
    assign dm_d0    = r_dm_d0;
    assign dm_d1    = r_dm_d1;
    assign dqs_d0   = r_dqs_d0;
    assign dqs_d1   = r_dqs_d1;
    assign dq_oe    = r_dq_oe;
    assign dqs_oe   = r_dqs_oe;
    assign underrun = r_underrun;
    assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: doc/hpdmc_wrpath.md
HPDMC_WRPATH -- requirements
Module: hpdmc_wrpath

Parametrised DDR write-path sequencer: buffers write words, sequences the DQS preamble, data and postamble, and drives ODDR2 D0/D1 pairs for DQ, DM and DQS. Successor to the fixed 2/4-byte ODDR bank.

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 32, meaning DQ pin count; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO depth in words; legal values are powers of 2, from 2 to 64.
REQ-003 SHALL have parameter BURST_CYCLES, default 2, meaning sys_clk cycles of data per burst; legal range 1 to 8.
REQ-004 SHALL have parameter LATENCY, default 1, meaning sys_clk cycles between the accepted start and the preamble; legal range 0 to 7.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 sys_clk  in  1  sole clock.
REQ-007 sys_rst  in  1  synchronous, active-high reset.
REQ-008 wr_valid  in  1  write word offered.
REQ-009 wr_ready  out  1  FIFO can accept a word.
REQ-010 wr_data  in  2*DQ_WIDTH  [2W-1:W] is the rising-edge beat; [W-1:0] is the falling-edge beat.
REQ-011 wr_mask  in  2*DQ_WIDTH/8  byte masks, split the same way as wr_data; 1 = byte masked.
REQ-012 burst_start  in  1  request one write burst.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 dq_d0, dq_d1  out  DQ_WIDTH each  ODDR2 D0/D1 inputs for DQ.
REQ-015 dm_d0, dm_d1  out  DQ_WIDTH/8 each  ODDR2 D0/D1 inputs for DM.
REQ-016 dqs_d0, dqs_d1  out  DQ_WIDTH/8 each  ODDR2 D0/D1 inputs for DQS.
REQ-017 dq_oe  out  1  DQ/DM tristate enable; 1 = drive.
REQ-018 dqs_oe  out  1  DQS tristate enable; 1 = drive.
REQ-019 underrun  out  1  sticky flag: FIFO was empty during a DATA cycle.
REQ-020 cmd_err  out  1  sticky flag: burst_start arrived while busy.

Function
REQ-021 A push SHALL occur on every cycle where wr_valid && wr_ready.
REQ-022 wr_ready SHALL equal (count != DEPTH), where count is a registered occupancy counter of width log2(DEPTH)+1.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 FSM states SHALL be IDLE, WAIT, PRE, DATA and POST.
REQ-026 In IDLE, burst_start SHALL move the FSM to WAIT when LATENCY>0, or to PRE when LATENCY=0.
REQ-027 WAIT SHALL last exactly LATENCY cycles, then go to PRE; the first PRE cycle is therefore cycle t+1+LATENCY after burst_start at cycle t.
REQ-028 PRE SHALL last 1 cycle, then go to DATA.
REQ-029 DATA SHALL last BURST_CYCLES cycles, then go to POST.
REQ-030 POST SHALL last 1 cycle, then go to IDLE.
REQ-031 burst_start in any state other than IDLE SHALL be ignored and SHALL set cmd_err.
REQ-032 All data/strobe outputs SHALL be registered and SHALL reflect the state held during that cycle.
REQ-033 In PRE: dqs_oe=1, dqs_d0=0, dqs_d1=0, dq_oe=0.
REQ-034 In DATA: dqs_oe=1, dq_oe=1, dqs_d0 all ones, dqs_d1 all zeros.
REQ-035 In DATA, each cycle SHALL pop one FIFO word onto dq_d0/dq_d1 and dm_d0/dm_d1.
REQ-036 In DATA with the FIFO empty: no pop; dq outputs = 0; dm outputs all ones (all bytes masked); underrun set.
REQ-037 In POST: dqs_oe=1, dqs outputs 0, dq_oe=0.
REQ-038 In IDLE and WAIT: dq_oe=0, dqs_oe=0, dq/dqs outputs 0, dm outputs all ones.
REQ-039 A push SHALL be permitted in every state, including in the same cycle as a DATA pop.
REQ-040 A burst SHALL consume at most BURST_CYCLES words; remaining words stay queued for the next burst.

Reset
REQ-041 On sys_rst=1 at a clock edge, the FSM SHALL go to IDLE and the FIFO SHALL be emptied (count=0, pointers=0).
REQ-042 On reset: underrun=0, cmd_err=0, busy=0, dq_oe=0, dqs_oe=0, all d0/d1 outputs 0 except dm outputs all ones.
REQ-043 wr_ready SHALL be 1 in the cycle after reset.
REQ-044 Reset during any state, including mid-DATA, SHALL take effect at the next edge, and the burst is abandoned with no further pops.
REQ-045 A push offered in the reset cycle SHALL be discarded.

Verification
REQ-046 With defaults: push A=64'h1111_2222_3333_4444 and B=64'h5555_6666_7777_8888 (masks 0), then pulse burst_start at cycle t -> PRE at t+2; DATA at t+3 gives dq_d0=32'h1111_2222, dq_d1=32'h3333_4444; DATA at t+4 gives dq_d0=32'h5555_6666, dq_d1=32'h7777_8888; POST at t+5; IDLE at t+6; dqs_oe high t+2..t+5.
REQ-047 With DEPTH=8: push 8 words with no burst -> wr_ready=0 after the 8th push; a 9th wr_valid is not accepted; start a burst -> wr_ready=1 in the cycle after the first DATA pop.
REQ-048 Push 1 word, BURST_CYCLES=2, start a burst -> the second DATA cycle drives dm all ones and dq=0, underrun=1 and stays 1 until reset.
REQ-049 Pulse burst_start during WAIT and again during DATA -> burst timing is unchanged and cmd_err=1.
REQ-050 Assert sys_rst in the first DATA cycle -> next cycle IDLE, oe=0, count=0, flags cleared, wr_ready=1.
REQ-051 With DQ_WIDTH=16, LATENCY=0 -> PRE follows burst_start by 1 cycle, and dqs_d0 width is 2.
